// File: rtl/mouse_cmd_arbiter.sv
// mouse_cmd_arbiter
// Shares one PS/2 transmit path between two command requesters.
// Requester 0 is the mouse init/master FSM; requester 1 is a user
// command source. A granted command byte is sent, the mouse's reply
// is collected, and a 0xFE reply causes a resend up to MAX_RETRY
// times. Each wait state has its own timeout. The transaction ends
// with a one-cycle DONEx pulse that carries STATUS.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   REQ0/REQ1, REQx_BYTE       request levels and their command bytes
//   GNT[1:0]                   one-hot grant, held through the DONE cycle
//   DONE0/DONE1, STATUS[1:0]   completion pulse and result
//                              (00 ack, 01 retries exhausted, 10 timeout,
//                               11 bad byte or receiver error)
//   BUSY                       FSM not idle
//   SEND_BYTE, BYTE_TO_SEND    transmitter strobe and data
//   BYTE_SENT                  transmitter done
//   READ_ENABLE                receiver enable (WAIT_ACK only)
//   BYTE_READ, BYTE_ERROR_CODE, BYTE_READY   receiver result
module mouse_cmd_arbiter #(
  parameter int TIMEOUT   = 200000,
  parameter int TIMEOUT_W = 18,
  parameter int MAX_RETRY = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] REQ0_BYTE,
  input  logic [7:0] REQ1_BYTE,
  output logic [1:0] GNT,
  output logic       DONE0,
  output logic       DONE1,
  output logic [1:0] STATUS,
  output logic       BUSY,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0] ST_ACK     = 2'b00;
  localparam logic [1:0] ST_RETRY   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BAD     = 2'b11;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_ACK, DONE} stateT;

  stateT                state, stateNext;
  logic [1:0]           gntNext;
  logic [7:0]           byteNext;
  logic [1:0]           statusNext;
  logic [RETRY_W-1:0]   retryCnt, retryNext;
  logic [TIMEOUT_W-1:0] tmoCnt;
  logic                 timedOut;
  // 1 means requester 1 was served last, so requester 0 wins a tie.
  logic                 lastServed, lastNext;
  logic                 inWait;

  assign timedOut = (tmoCnt == TIMEOUT_W'(TIMEOUT - 1));
  assign inWait   = (state == WAIT_SENT) || (state == WAIT_ACK);

  always_comb begin
    stateNext  = state;
    gntNext    = GNT;
    byteNext   = BYTE_TO_SEND;
    statusNext = ST_ACK;
    retryNext  = retryCnt;
    lastNext   = lastServed;
    case (state)
      IDLE: begin
        if (REQ0 && (!REQ1 || lastServed)) begin
          gntNext   = 2'b01;
          byteNext  = REQ0_BYTE;
          retryNext = '0;
          stateNext = SEND;
        end else if (REQ1) begin
          gntNext   = 2'b10;
          byteNext  = REQ1_BYTE;
          retryNext = '0;
          stateNext = SEND;
        end
      end
      SEND: stateNext = WAIT_SENT;
      WAIT_SENT: begin
        // A completion on the final timeout cycle still counts.
        if (BYTE_SENT) begin
          stateNext = WAIT_ACK;
        end else if (timedOut) begin
          stateNext  = DONE;
          statusNext = ST_TIMEOUT;
        end
      end
      WAIT_ACK: begin
        if (BYTE_READY) begin
          stateNext = DONE;
          if (BYTE_ERROR_CODE != 2'b00) begin
            statusNext = ST_BAD;
          end else if (BYTE_READ == 8'hFA) begin
            statusNext = ST_ACK;
          end else if (BYTE_READ == 8'hFE) begin
            if (retryCnt < RETRY_W'(MAX_RETRY)) begin
              retryNext = retryCnt + RETRY_W'(1);
              stateNext = SEND;
            end else begin
              statusNext = ST_RETRY;
            end
          end else begin
            statusNext = ST_BAD;
          end
        end else if (timedOut) begin
          stateNext  = DONE;
          statusNext = ST_TIMEOUT;
        end
      end
      DONE: begin
        stateNext = IDLE;
        gntNext   = 2'b00;
        lastNext  = GNT[1];
      end
      default: stateNext = IDLE;
    endcase
  end

  // All outputs are registered off the next-state decision so that
  // they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      GNT          <= 2'b00;
      DONE0        <= 1'b0;
      DONE1        <= 1'b0;
      STATUS       <= 2'b00;
      BUSY         <= 1'b0;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= 8'h00;
      READ_ENABLE  <= 1'b0;
      retryCnt     <= '0;
      tmoCnt       <= '0;
      lastServed   <= 1'b1;
    end else begin
      state        <= stateNext;
      GNT          <= gntNext;
      DONE0        <= (stateNext == DONE) && gntNext[0];
      DONE1        <= (stateNext == DONE) && gntNext[1];
      STATUS       <= statusNext;
      BUSY         <= (stateNext != IDLE);
      SEND_BYTE    <= (stateNext == SEND);
      BYTE_TO_SEND <= byteNext;
      READ_ENABLE  <= (stateNext == WAIT_ACK);
      retryCnt     <= retryNext;
      lastServed   <= lastNext;
      // Restart on every state change; saturate rather than wrap.
      if (!inWait || (stateNext != state))
        tmoCnt <= '0;
      else if (tmoCnt != {TIMEOUT_W{1'b1}})
        tmoCnt <= tmoCnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_mouse_cmd_arbiter.sv
module tb_mouse_cmd_arbiter;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0, REQ1;
  logic [7:0] REQ0_BYTE, REQ1_BYTE;
  logic [1:0] GNT;
  logic       DONE0, DONE1;
  logic [1:0] STATUS;
  logic       BUSY, SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  int checks = 0;
  int errors = 0;

  mouse_cmd_arbiter #(.TIMEOUT(TO), .TIMEOUT_W(5), .MAX_RETRY(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .REQ0_BYTE(REQ0_BYTE), .REQ1_BYTE(REQ1_BYTE),
    .GNT(GNT), .DONE0(DONE0), .DONE1(DONE1), .STATUS(STATUS), .BUSY(BUSY),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called in a SEND cycle: BYTE_SENT on the first WAIT_SENT cycle, then
  // the reply on the first WAIT_ACK cycle. Returns in the following cycle.
  task automatic ackSeq(input logic [7:0] reply, input logic [1:0] err);
    step();
    BYTE_SENT = 1'b1;
    step();
    BYTE_SENT = 1'b0;
    BYTE_READY = 1'b1; BYTE_READ = reply; BYTE_ERROR_CODE = err;
    step();
    BYTE_READY = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
  endtask

  initial begin
    int doneSeen;
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; REQ0_BYTE = 8'h00; REQ1_BYTE = 8'h00;
    BYTE_SENT = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00; BYTE_READY = 1'b0;
    step(); step();
    chk("reset_outputs", {15'd0, GNT, DONE0, DONE1, STATUS, BUSY, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE}, 32'd0);
    RESET = 1'b0;
    step();
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    // Single request 1, 0xF3, BYTE_SENT five cycles later, then 0xFA.
    REQ1 = 1'b1; REQ1_BYTE = 8'hF3;
    step();
    chk("t1_gnt", {30'd0, GNT}, 32'h2);
    chk("t1_send", {23'd0, SEND_BYTE, BYTE_TO_SEND}, {23'd0, 1'b1, 8'hF3});
    step();
    chk("t1_send_pulse", {31'd0, SEND_BYTE}, 32'd0);
    step(); step(); step();
    BYTE_SENT = 1'b1;
    step();
    BYTE_SENT = 1'b0;
    chk("t1_read_en", {31'd0, READ_ENABLE}, 32'd1);
    chk("t1_no_done_yet", {30'd0, DONE1, DONE0}, 32'd0);
    BYTE_READY = 1'b1; BYTE_READ = 8'hFA;
    step();
    BYTE_READY = 1'b0; REQ1 = 1'b0;
    chk("t1_done", {26'd0, DONE1, DONE0, STATUS, GNT}, {26'd0, 2'b10, 2'b00, 2'b10});
    step();
    chk("t1_idle", {28'd0, BUSY, DONE1, GNT}, 32'd0);

    // Both held: served last was 1, so order 0, 1, 0.
    REQ0 = 1'b1; REQ0_BYTE = 8'h11; REQ1 = 1'b1; REQ1_BYTE = 8'h22;
    step();
    chk("rr1_gnt", {30'd0, GNT}, 32'h1);
    chk("rr1_byte", {24'd0, BYTE_TO_SEND}, 32'h11);
    ackSeq(8'hFA, 2'b00);
    chk("rr1_done", {28'd0, DONE1, DONE0, GNT}, {28'd0, 2'b01, 2'b01});
    step();
    chk("rr1_idle_gnt", {30'd0, GNT}, 32'd0);
    step();
    chk("rr2_gnt", {30'd0, GNT}, 32'h2);
    chk("rr2_byte", {24'd0, BYTE_TO_SEND}, 32'h22);
    ackSeq(8'hFA, 2'b00);
    chk("rr2_done", {28'd0, DONE1, DONE0, GNT}, {28'd0, 2'b10, 2'b10});
    step();
    step();
    chk("rr3_gnt", {30'd0, GNT}, 32'h1);
    ackSeq(8'hFA, 2'b00);
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("rr3_done", {28'd0, DONE1, DONE0, GNT}, {28'd0, 2'b01, 2'b01});
    step();

    // Three 0xFE replies: two resends, then retries exhausted.
    REQ0 = 1'b1; REQ0_BYTE = 8'hF4;
    step();
    chk("rt_send0", {23'd0, SEND_BYTE, BYTE_TO_SEND}, {23'd0, 1'b1, 8'hF4});
    ackSeq(8'hFE, 2'b00);
    chk("rt_send1", {21'd0, GNT, DONE0, SEND_BYTE, BYTE_TO_SEND}, {21'd0, 2'b01, 1'b0, 1'b1, 8'hF4});
    ackSeq(8'hFE, 2'b00);
    chk("rt_send2", {21'd0, GNT, DONE0, SEND_BYTE, BYTE_TO_SEND}, {21'd0, 2'b01, 1'b0, 1'b1, 8'hF4});
    ackSeq(8'hFE, 2'b00);
    REQ0 = 1'b0;
    chk("rt_done", {27'd0, SEND_BYTE, DONE0, STATUS}, {27'd0, 1'b0, 1'b1, 2'b01});
    step();

    // BYTE_SENT never arrives: DONE 16 cycles after entering WAIT_SENT.
    REQ1 = 1'b1; REQ1_BYTE = 8'hE8;
    step();
    step();
    doneSeen = 0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      if (DONE1) doneSeen++;
    end
    chk("to_early_done", doneSeen, 0);
    step();
    REQ1 = 1'b0;
    chk("to_done", {29'd0, DONE1, STATUS}, {29'd0, 1'b1, 2'b10});
    step();

    // Unexpected byte.
    REQ0 = 1'b1; REQ0_BYTE = 8'h01;
    step();
    ackSeq(8'hAA, 2'b00);
    REQ0 = 1'b0;
    chk("bad_byte", {29'd0, DONE0, STATUS}, {29'd0, 1'b1, 2'b11});
    step();

    // Receiver error takes priority over an otherwise good 0xFA.
    REQ1 = 1'b1; REQ1_BYTE = 8'h02;
    step();
    ackSeq(8'hFA, 2'b01);
    REQ1 = 1'b0;
    chk("rx_err", {29'd0, DONE1, STATUS}, {29'd0, 1'b1, 2'b11});
    step();

    // Reply on the final timeout cycle of WAIT_ACK reports the byte.
    REQ0 = 1'b1; REQ0_BYTE = 8'h03;
    step();
    step();
    BYTE_SENT = 1'b1;
    step();
    BYTE_SENT = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      if (DONE0 || !READ_ENABLE) doneSeen++;
    end
    chk("tie_still_waiting", doneSeen, 0);
    BYTE_READY = 1'b1; BYTE_READ = 8'hFA;
    step();
    BYTE_READY = 1'b0; REQ0 = 1'b0;
    chk("tie_status", {29'd0, DONE0, STATUS}, {29'd0, 1'b1, 2'b00});
    step();

    // Reset in WAIT_ACK aborts silently.
    REQ1 = 1'b1; REQ1_BYTE = 8'h33;
    step();
    step();
    BYTE_SENT = 1'b1;
    step();
    BYTE_SENT = 1'b0;
    chk("rst_in_ack", {31'd0, READ_ENABLE}, 32'd1);
    RESET = 1'b1; REQ1 = 1'b0;
    step();
    chk("rst_outputs", {15'd0, GNT, DONE0, DONE1, STATUS, BUSY, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE}, 32'd0);
    RESET = 1'b0;
    step();
    chk("rst_no_done", {29'd0, DONE1, DONE0, BUSY}, 32'd0);
    REQ1 = 1'b1; REQ1_BYTE = 8'h44;
    step();
    chk("post_rst_gnt", {22'd0, GNT, BYTE_TO_SEND}, {22'd0, 2'b10, 8'h44});
    ackSeq(8'hFA, 2'b00);
    REQ1 = 1'b0;
    chk("post_rst_done", {29'd0, DONE1, STATUS}, {29'd0, 1'b1, 2'b00});
    step();
    chk("post_rst_idle", {29'd0, BUSY, GNT}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
